ws2812_driver: RTL

Downstream consumer of the color stage: captures each 24-bit `{R,G,B}` word presented with a one-cycle valid strobe into a small FIFO. Once a full frame of `LEDS` words is buffered, it serializes the frame onto a single WS2812-style LED data line and then holds a latch/reset gap. It sits between the per-note color pipeline and the board's LED strip pin, and absorbs bursty color output without back-pressure.

---
 rtl/ws2812_driver_if.sv | 32 +++
 rtl/ws2812_driver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_driver_if.sv
// ============================================================================
//  Module   : ws2812_driver_if
//  Brief    : Color-word input and LED-line status bundle for ws2812_driver.
//             master = color producer, slave = LED driver.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ws2812_driver_if #(
  parameter int DEPTH = 16
);
  logic [23:0]              rgb_i;
  logic                     data_v_i;
  logic                     clear_ovf_i;
  logic                     led_o;
  logic                     busy_o;
  logic                     frame_done_o;
  logic                     overflow_o;
  logic [$clog2(DEPTH):0]   level_o;

  modport master (
    output rgb_i, data_v_i, clear_ovf_i,
    input  led_o, busy_o, frame_done_o, overflow_o, level_o
  );

  modport slave (
    input  rgb_i, data_v_i, clear_ovf_i,
    output led_o, busy_o, frame_done_o, overflow_o, level_o
  );
endinterface

`default_nettype wire

// File: rtl/ws2812_driver.sv
// ============================================================================
//  Module   : ws2812_driver
//  Brief    : Buffers 24-bit color words in a FIFO and, once LEDS words are
//             present, serializes one frame onto a WS2812-style data line,
//             followed by a TLATCH-cycle low latch gap.
//  Macro    : WS2812_GRB_ORDER_EN - transmit each word as G,R,B instead of
//             R,G,B (load mapping only, timing unchanged).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ws2812_driver #(
  parameter int LEDS   = 12,
  parameter int DEPTH  = 16,
  parameter int T0H    = 20,
  parameter int T1H    = 40,
  parameter int TBIT   = 63,
  parameter int TLATCH = 2500
) (
  input  logic              clk,
  input  logic              rst,
  ws2812_driver_if.slave    bus
);

  localparam int C_PW   = $clog2(DEPTH);
  localparam int C_MAXC = (TBIT > TLATCH) ? TBIT : TLATCH;
  localparam int C_CW   = ($clog2(C_MAXC) < 1) ? 1 : $clog2(C_MAXC);
  localparam int C_LW   = ($clog2(LEDS + 1) < 1) ? 1 : $clog2(LEDS + 1);

  localparam logic [C_CW-1:0] C_T0H_END   = C_CW'(T0H - 1);
  localparam logic [C_CW-1:0] C_T1H_END   = C_CW'(T1H - 1);
  localparam logic [C_CW-1:0] C_TBIT_END  = C_CW'(TBIT - 1);
  localparam logic [C_CW-1:0] C_LATCH_END = C_CW'(TLATCH - 1);
  localparam logic [C_PW:0]   C_DEPTH     = (C_PW + 1)'(DEPTH);
  localparam logic [C_PW:0]   C_LEDS      = (C_PW + 1)'(LEDS);
  localparam logic [C_LW-1:0] C_LAST_LED  = C_LW'(LEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [23:0]     r_mem [DEPTH];
  logic [C_PW:0]   r_wptr;
  logic [C_PW:0]   r_rptr;

  // Serializer state
  state_t          r_state;
  logic [C_CW-1:0] r_cnt;
  logic [4:0]      r_bit;
  logic [C_LW-1:0] r_led_cnt;
  logic [23:0]     r_shift;
  logic            r_led;
  logic            r_busy;
  logic            r_fd;
  logic            r_ovf;

  logic [C_PW:0]   w_level;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_bit_end;
  logic [23:0]     w_rd_word;
  logic [23:0]     w_load_word;

  assign w_level   = r_wptr - r_rptr;
  assign w_full    = (w_level == C_DEPTH);
  assign w_empty   = (w_level == '0);
  assign w_bit_end = (r_cnt == C_TBIT_END);
  assign w_rd_word = r_mem[r_rptr[C_PW-1:0]];

`ifdef WS2812_GRB_ORDER_EN
  assign w_load_word = {w_rd_word[15:8], w_rd_word[23:16], w_rd_word[7:0]};
`else
  assign w_load_word = w_rd_word;
`endif

  // Pop the head word whenever the serializer starts a new LED; a full FIFO
  // still accepts a write in the same cycle it pops.
  always_comb begin
    w_pop  = 1'b0;
    if (!w_empty) begin
      if (r_state == S_LOAD) begin
        w_pop = 1'b1;
      end else if (r_state == S_LOW && w_bit_end && r_bit == 5'd23 &&
                   r_led_cnt != C_LAST_LED) begin
        w_pop = 1'b1;
      end
    end
    w_push = bus.data_v_i && (!w_full || w_pop);
    w_drop = bus.data_v_i && w_full && !w_pop;
  end

  // FIFO data array write (storage needs no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[C_PW-1:0]] <= bus.rgb_i;
    end
  end

  // FIFO pointers and sticky overflow flag (a drop wins over a clear)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.clear_ovf_i) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Serializer FSM: registered led/busy/frame_done outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_led_cnt <= '0;
      r_shift   <= '0;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_fd      <= 1'b0;
    end else begin
      r_fd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_led <= 1'b0;
          if (w_level >= C_LEDS) begin
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_shift   <= w_load_word;
          r_cnt     <= '0;
          r_bit     <= '0;
          r_led_cnt <= '0;
          r_led     <= 1'b1;
          r_state   <= S_HIGH;
        end
        S_HIGH: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == (r_shift[23] ? C_T1H_END : C_T0H_END)) begin
            r_led   <= 1'b0;
            r_state <= S_LOW;
          end
        end
        S_LOW: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit != 5'd23) begin
              r_shift <= {r_shift[22:0], 1'b0};
              r_bit   <= r_bit + 1'b1;
              r_led   <= 1'b1;
              r_state <= S_HIGH;
            end else if (r_led_cnt != C_LAST_LED) begin
              r_shift   <= w_load_word;
              r_bit     <= '0;
              r_led_cnt <= r_led_cnt + 1'b1;
              r_led     <= 1'b1;
              r_state   <= S_HIGH;
            end else begin
              r_state <= S_LATCH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          if (r_cnt == C_LATCH_END) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_fd    <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.led_o        = r_led;
  assign bus.busy_o       = r_busy;
  assign bus.frame_done_o = r_fd;
  assign bus.overflow_o   = r_ovf;
  assign bus.level_o      = w_level;

endmodule

`default_nettype wire
